// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//
// Definitions shared by the execute-stage ALU.
//   alu_op_t   : 4-bit operation select carried on ALUOp
//   ALU_*      : operation codes; any code not listed yields a zero result
//   ALU_WIDTH  : default operand/result width
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 4'b0000;
    localparam alu_op_t ALU_NOR  = 4'b0001;
    localparam alu_op_t ALU_OR   = 4'b0010;
    localparam alu_op_t ALU_XOR  = 4'b0011;
    localparam alu_op_t ALU_SLL  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_SRA  = 4'b0110;
    localparam alu_op_t ALU_SLT  = 4'b0111;
    localparam alu_op_t ALU_SLTU = 4'b1000;
    localparam alu_op_t ALU_ADD  = 4'b1010;
    localparam alu_op_t ALU_SUB  = 4'b1100;

endpackage

// File: rtl/alu_comb.sv
// ---------------------------------------------------------------------------
// alu_comb
//
// Purely combinational function unit of the ALU. Produces the value that the
// top level captures on the next rising edge.
//   a_i      : operand A
//   b_i      : operand B; its low log2(WIDTH) bits are the shift amount
//   aluOp_i  : operation select (alu_op_t)
//   result_o : operation result, WIDTH bits
// ---------------------------------------------------------------------------
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_t          aluOp_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int SHIFT_W = $clog2(WIDTH);

    logic [SHIFT_W-1:0] shiftAmt;
    logic               lessSigned;
    logic               lessUnsigned;

    // Only the low bits of b select a shift distance; the upper bits are
    // deliberately ignored so oversized amounts wrap rather than clear.
    assign shiftAmt     = b_i[SHIFT_W-1:0];
    assign lessSigned   = ($signed(a_i) < $signed(b_i));
    assign lessUnsigned = (a_i < b_i);

    // Operation select. Unassigned opcodes fall through to the zero default
    // so the Zero flag reads as set for them.
    always_comb begin
        result_o = '0;
        case (aluOp_i)
            ALU_AND:  result_o = a_i & b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << shiftAmt;
            ALU_SRL:  result_o = a_i >> shiftAmt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shiftAmt);
            ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, lessSigned};
            ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, lessUnsigned};
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//
// Registered 64-bit arithmetic/logic unit for the execute stage. The
// combinational result of alu_comb is captured on each rising clk edge along
// with a flag telling whether that captured value is zero.
//   clk    : system clock, rising-edge active
//   reset  : synchronous, active-high; clears result and sets Zero
//   a      : operand A
//   b      : operand B / shift amount
//   ALUOp  : operation select
//   result : registered operation result (one cycle latency)
//   Zero   : registered flag, 1 when result holds 0
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] result,
    output logic             Zero
);

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_d;
    logic             zero_q;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .a_i      (a),
        .b_i      (b),
        .aluOp_i  (alu_op_t'(ALUOp)),
        .result_o (result_d)
    );

    // The flag is derived from the same next-state value that goes into the
    // result register, so the two can never disagree after an edge.
    assign zero_d = (result_d == '0);

    // Output register. Reset wins over whatever operation is pending and
    // leaves the unit in the "result is zero" state.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign Zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
//
// Self-checking bench for the registered ALU: directed steps from known
// values followed by randomized operations compared against a behavioural
// model computed with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_alu;
    import alu_pkg::*;

    localparam logic [63:0] MSB_ONLY = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ALUOp;
    logic [63:0] result;
    logic        Zero;

    int checks;
    int errors;

    alu #(
        .WIDTH (64)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .ALUOp  (ALUOp),
        .result (result),
        .Zero   (Zero)
    );

    // 20 ns period, rising edges at 10, 30, 50, ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference model: what the unit should hold after an edge, worked out
    // from arithmetic on the operands rather than bit manipulation.
    function automatic logic [63:0] refModel(input logic [3:0] op,
                                             input logic [63:0] x,
                                             input logic [63:0] y);
        longint unsigned pow2;
        int              sh;
        logic [63:0]     r;
        sh   = int'(y % 64);
        pow2 = 1;
        for (int k = 0; k < sh; k++) pow2 = pow2 * 2;
        r = 64'd0;
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = ~(x | y);
            4'b0010: r = x | y;
            4'b0011: r = x ^ y;
            4'b0100: r = x * pow2;
            4'b0101: r = x / pow2;
            4'b0110: r = (x[63]) ? ~((~x) / pow2) : (x / pow2);
            4'b0111: r = (longint'(x) < longint'(y)) ? 64'd1 : 64'd0;
            4'b1000: r = (x < y) ? 64'd1 : 64'd0;
            4'b1010: r = x + y;
            4'b1100: r = x - y;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Drive one set of inputs mid-cycle and wait for the capturing edge,
    // then step 1 ns clear of it before anything is sampled.
    task automatic applyStimulus(input logic rst, input logic [3:0] op,
                                 input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        reset = rst;
        ALUOp = op;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] expRes,
                               input logic expZero);
        checks++;
        assert (result === expRes)
        else begin
            errors++;
            $error("[TB] FAIL %s result got %h expected %h", tag, result, expRes);
        end
        checks++;
        assert (Zero === expZero)
        else begin
            errors++;
            $error("[TB] FAIL %s Zero got %b expected %b", tag, Zero, expZero);
        end
    endtask

    initial begin
        logic        rst;
        logic [3:0]  op;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] exp;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        ALUOp  = 4'b0;
        a      = 64'd0;
        b      = 64'd0;

        $display("[TB] start");

        // Reset clears the register even with a nonzero operation pending
        applyStimulus(1'b1, ALU_ADD, 64'd10, 64'd15);
        checkOutput("reset", 64'd0, 1'b1);

        // Logical operations, a=10 b=15
        applyStimulus(1'b0, ALU_AND, 64'd10, 64'd15);
        checkOutput("and_10_15", 64'd10, 1'b0);
        applyStimulus(1'b0, ALU_NOR, 64'd10, 64'd15);
        checkOutput("nor_10_15", 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        applyStimulus(1'b0, ALU_OR, 64'd10, 64'd15);
        checkOutput("or_10_15", 64'd15, 1'b0);
        applyStimulus(1'b0, ALU_XOR, 64'd10, 64'd15);
        checkOutput("xor_10_15", 64'd5, 1'b0);

        // Arithmetic, compare and shift, a=10 b=15
        applyStimulus(1'b0, ALU_ADD, 64'd10, 64'd15);
        checkOutput("add_10_15", 64'd25, 1'b0);
        applyStimulus(1'b0, ALU_SUB, 64'd10, 64'd15);
        checkOutput("sub_10_15", 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        applyStimulus(1'b0, ALU_SLT, 64'd10, 64'd15);
        checkOutput("slt_10_15", 64'd1, 1'b0);
        applyStimulus(1'b0, ALU_SLTU, 64'd10, 64'd15);
        checkOutput("sltu_10_15", 64'd1, 1'b0);
        applyStimulus(1'b0, ALU_SLL, 64'd10, 64'd15);
        checkOutput("sll_10_15", 64'd327680, 1'b0);
        applyStimulus(1'b0, ALU_SRL, 64'd10, 64'd15);
        checkOutput("srl_10_15", 64'd0, 1'b1);

        // Sign-bit and wrap-around boundaries
        applyStimulus(1'b0, ALU_SUB, MSB_ONLY, MSB_ONLY);
        checkOutput("sub_msb_msb", 64'd0, 1'b1);
        applyStimulus(1'b0, ALU_ADD, MSB_ONLY, MSB_ONLY);
        checkOutput("add_msb_wrap", 64'd0, 1'b1);
        applyStimulus(1'b0, ALU_SRA, MSB_ONLY, 64'd63);
        checkOutput("sra_msb_63", ALL_ONES, 1'b0);
        applyStimulus(1'b0, ALU_SLT, MSB_ONLY, 64'd0);
        checkOutput("slt_msb_0", 64'd1, 1'b0);
        applyStimulus(1'b0, ALU_SLTU, MSB_ONLY, 64'd0);
        checkOutput("sltu_msb_0", 64'd0, 1'b1);
        applyStimulus(1'b0, ALU_SRL, MSB_ONLY, 64'h40 | 64'd63);
        checkOutput("srl_upper_b_ignored", 64'd1, 1'b0);

        // a=3 b=0: zero shift passes a, undefined code clears
        applyStimulus(1'b0, ALU_SUB, 64'd3, 64'd0);
        checkOutput("sub_3_0", 64'd3, 1'b0);
        applyStimulus(1'b0, ALU_SLL, 64'd3, 64'd0);
        checkOutput("sll_3_0", 64'd3, 1'b0);
        applyStimulus(1'b0, ALU_AND, 64'd3, 64'd0);
        checkOutput("and_3_0", 64'd0, 1'b1);
        applyStimulus(1'b0, 4'b1111, 64'd3, 64'd0);
        checkOutput("undef_1111", 64'd0, 1'b1);
        applyStimulus(1'b0, 4'b1001, 64'd10, 64'd15);
        checkOutput("undef_1001", 64'd0, 1'b1);

        // Only the opcode present at the edge is captured
        @(posedge clk);
        a     = 64'd10;
        b     = 64'd15;
        reset = 1'b0;
        #7 ALUOp = ALU_SUB;
        #7 ALUOp = ALU_OR;
        @(posedge clk);
        #1;
        checkOutput("mid_cycle_change", 64'd15, 1'b0);

        // Reset alongside an ADD, then capture resumes on the next edge
        applyStimulus(1'b1, ALU_ADD, 64'd10, 64'd15);
        checkOutput("reset_with_add", 64'd0, 1'b1);
        applyStimulus(1'b0, ALU_ADD, 64'd10, 64'd15);
        checkOutput("resume_after_reset", 64'd25, 1'b0);

        // Randomized operations with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 15) == 0);
            op  = 4'($urandom_range(0, 15));
            x   = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       y = 64'($urandom_range(0, 63));
                1:       y = x;
                default: y = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 7) == 0) x = MSB_ONLY;
            exp = rst ? 64'd0 : refModel(op, x, y);
            applyStimulus(rst, op, x, y);
            checkOutput($sformatf("rand%0d_op%0h", i, op), exp, (exp == 64'd0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
